// File: rtl/osc_entropy_pkg.sv
// Shared types and default sizing for the oscillator entropy collector.
package osc_entropy_pkg;

    typedef enum logic {
        PAIR_EMPTY = 1'b0,
        PAIR_HALF  = 1'b1
    } pair_state_t;

    localparam int DEF_NUM_OSC     = 16;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_SAMPLE_DIV  = 16;
    localparam int DEF_STUCK_LIMIT = 64;

endpackage

// File: rtl/vn_debias.sv
// Von Neumann pair debiaser: 10 -> 1, 01 -> 0, 00/11 discarded.
module vn_debias
    import osc_entropy_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic sample,
    input  logic raw,
    input  logic hold,
    input  logic clear,
    output logic bit_valid,
    output logic bit_data
);

    pair_state_t state;
    logic        first_bit;
    logic        advance;

    assign advance = sample && !hold;

    always_comb begin
        bit_valid = advance && (state == PAIR_HALF) && (raw != first_bit);
        bit_data  = first_bit;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state <= PAIR_EMPTY;
        end else if (advance) begin
            state <= (state == PAIR_EMPTY) ? PAIR_HALF : PAIR_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (advance && (state == PAIR_EMPTY)) begin
            first_bit <= raw;
        end
    end

endmodule

// File: rtl/osc_entropy_collector.sv
// Synchronises and XOR-combines oscillator outputs, debiases the raw stream,
// packs it into words behind a valid/ready output, and watches for stuck raw data.
module osc_entropy_collector
    import osc_entropy_pkg::*;
#(
    parameter int NUM_OSC     = DEF_NUM_OSC,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int SAMPLE_DIV  = DEF_SAMPLE_DIV,
    parameter int STUCK_LIMIT = DEF_STUCK_LIMIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_OSC-1:0]    osc_in,
    output logic [DATA_WIDTH-1:0] entropy_data,
    output logic                  entropy_valid,
    input  logic                  entropy_ready,
    output logic                  stuck_error
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam int BC_W  = $clog2(DATA_WIDTH + 1);
    localparam int RUN_W = $clog2(STUCK_LIMIT + 1);

    function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
        return (v == RUN_W'(STUCK_LIMIT)) ? v : v + 1'b1;
    endfunction

    logic [NUM_OSC-1:0]    sync_p0, sync_p1;
    logic                  raw;
    logic                  en_p0;
    logic [CNT_W-1:0]      sample_cnt;
    logic                  samp_vld_p0, samp_raw_p0;
    logic [DATA_WIDTH-1:0] shift;
    logic [BC_W-1:0]       bit_count;
    logic [RUN_W-1:0]      run_count, run_next;
    logic                  prev_raw;
    logic                  full, load, paused, run, take;
    logic                  bit_valid, bit_data;

    // Stage p0/p1: two-flop synchroniser; free-running regardless of enable.
    always_ff @(posedge clk) begin
        sync_p0 <= osc_in;
        sync_p1 <= sync_p0;
    end

    assign raw = ^sync_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            en_p0 <= 1'b0;
        end else begin
            en_p0 <= enable;
        end
    end

    // A full word with the output still occupied stalls sampling, including the transfer cycle.
    always_comb begin
        full   = (bit_count == BC_W'(DATA_WIDTH));
        load   = full && (!entropy_valid || entropy_ready);
        paused = full && entropy_valid;
        run    = enable && en_p0 && !paused;
        take   = run && (sample_cnt == CNT_W'(SAMPLE_DIV - 1));
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            sample_cnt <= '0;
        end else if (run) begin
            sample_cnt <= (sample_cnt == CNT_W'(SAMPLE_DIV - 1)) ? '0 : sample_cnt + 1'b1;
        end
    end

    // Sample stage boundary: register the strobe and raw bit ahead of the pair FSM.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            samp_vld_p0 <= 1'b0;
        end else begin
            samp_vld_p0 <= take;
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            samp_raw_p0 <= raw;
        end
    end

    assign run_next = ((run_count == '0) || (raw != prev_raw)) ? RUN_W'(1) : sat_inc(run_count);

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            run_count   <= '0;
            prev_raw    <= 1'b0;
            stuck_error <= 1'b0;
        end else if (take) begin
            prev_raw  <= raw;
            run_count <= run_next;
            if (run_next == RUN_W'(STUCK_LIMIT)) begin
                stuck_error <= 1'b1;
            end
        end
    end

    vn_debias u_vn (
        .clk       (clk),
        .reset     (reset),
        .sample    (samp_vld_p0),
        .raw       (samp_raw_p0),
        .hold      (stuck_error || paused),
        .clear     (!enable),
        .bit_valid (bit_valid),
        .bit_data  (bit_data)
    );

    // Packer: a load and a new bit never coincide because a sample needs a cycle to reach the pair FSM.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            shift     <= '0;
            bit_count <= '0;
        end else if (load) begin
            bit_count <= '0;
        end else if (bit_valid) begin
            shift     <= {shift[DATA_WIDTH-2:0], bit_data};
            bit_count <= bit_count + 1'b1;
        end
    end

    // Output stage boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            entropy_data  <= '0;
            entropy_valid <= 1'b0;
        end else if (load) begin
            entropy_data  <= shift;
            entropy_valid <= 1'b1;
        end else if (entropy_valid && entropy_ready) begin
            entropy_valid <= 1'b0;
        end
    end

endmodule
